// File: rtl/fifo_flag_ctrl_if.sv
// Request/pointer/status bundle between the FIFO flag controller and its users.
// The master side drives requests and pointers; the slave side (controller) returns grants and flags.
interface fifo_flag_ctrl_if #(
    parameter int unsigned ADDRESS_SIZE = 2
);
    localparam int unsigned PW = ADDRESS_SIZE + 1;

    logic          wr_req;
    logic          rd_req;
    logic          err_clr;
    logic [PW-1:0] w_ptr;
    logic [PW-1:0] r_ptr;
    logic          cw_en;
    logic          cr_en;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [PW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic          ptr_err;

    modport master (
        output wr_req, rd_req, err_clr, w_ptr, r_ptr,
        input  cw_en, cr_en, full, empty, almost_full, almost_empty,
               count, overflow, underflow, ptr_err
    );

    modport slave (
        input  wr_req, rd_req, err_clr, w_ptr, r_ptr,
        output cw_en, cr_en, full, empty, almost_full, almost_empty,
               count, overflow, underflow, ptr_err
    );
endinterface

// File: rtl/fifo_flag_ctrl.sv
// FIFO control/status stage: grants counter enables from registered flags, tracks occupancy,
// and keeps sticky overflow/underflow/pointer-consistency errors.
module fifo_flag_ctrl #(
    parameter int unsigned MEMORY_DEPTH = 4,
    parameter int unsigned ADDRESS_SIZE = 2,
    parameter int unsigned AF_LEVEL     = 3,
    parameter int unsigned AE_LEVEL     = 1
) (
    input  logic                clk,
    input  logic                rst,
    fifo_flag_ctrl_if.slave     bus
);
    localparam int unsigned PW = ADDRESS_SIZE + 1;

    logic [PW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_almost_full;
    logic          r_almost_empty;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_ptr_err;

    logic          w_cw_en;
    logic          w_cr_en;
    logic [PW-1:0] w_count_next;
    logic [PW-1:0] w_ptr_diff;

    // Grants depend only on registered flags, so there is no rd_req -> cw_en path
    assign w_cw_en      = bus.wr_req & ~r_full;
    assign w_cr_en      = bus.rd_req & ~r_empty;
    assign w_count_next = r_count + PW'(w_cw_en) - PW'(w_cr_en);
    // Modulo subtraction stays correct across pointer MSB toggles
    assign w_ptr_diff   = bus.w_ptr - bus.r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_ptr_err      <= 1'b0;
        end else begin
            r_count        <= w_count_next;
            r_full         <= (w_count_next == PW'(MEMORY_DEPTH));
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= PW'(AF_LEVEL));
            r_almost_empty <= (w_count_next <= PW'(AE_LEVEL));
            // Sticky errors: a set in the same cycle as err_clr takes priority
            r_overflow     <= (bus.wr_req & r_full)  | (r_overflow  & ~bus.err_clr);
            r_underflow    <= (bus.rd_req & r_empty) | (r_underflow & ~bus.err_clr);
            r_ptr_err      <= (w_ptr_diff != r_count) | (r_ptr_err & ~bus.err_clr);
        end
    end

    assign bus.cw_en        = w_cw_en;
    assign bus.cr_en        = w_cr_en;
    assign bus.count        = r_count;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
    assign bus.ptr_err      = r_ptr_err;
endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Directed plus randomized bench for fifo_flag_ctrl against an integer-occupancy reference model,
// with write/read pointer counters that follow the DUT grants.
module tb_fifo_flag_ctrl;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned AF    = 3;
    localparam int unsigned AE    = 1;
    localparam int          PMOD  = 1 << PW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_flag_ctrl_if #(.ADDRESS_SIZE(AW)) bus ();

    fifo_flag_ctrl #(
        .MEMORY_DEPTH(DEPTH),
        .ADDRESS_SIZE(AW),
        .AF_LEVEL    (AF),
        .AE_LEVEL    (AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Address counters driven by the grants, reset together with the controller
    logic [PW-1:0] w_cnt;
    logic [PW-1:0] r_cnt;
    logic [PW-1:0] ptr_off = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt <= '0;
            r_cnt <= '0;
        end else begin
            if (bus.cw_en) w_cnt <= w_cnt + PW'(1);
            if (bus.cr_en) r_cnt <= r_cnt + PW'(1);
        end
    end
    assign bus.w_ptr = w_cnt + ptr_off;
    assign bus.r_ptr = r_cnt;

    int checks   = 0;
    int failures = 0;

    int m_count = 0;
    bit m_ovf   = 1'b0;
    bit m_udf   = 1'b0;
    bit m_perr  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":count"},        32'(bus.count),        32'(m_count));
        chk({ph, ":full"},         32'(bus.full),         32'(m_count == int'(DEPTH)));
        chk({ph, ":empty"},        32'(bus.empty),        32'(m_count == 0));
        chk({ph, ":almost_full"},  32'(bus.almost_full),  32'(m_count >= int'(AF)));
        chk({ph, ":almost_empty"}, 32'(bus.almost_empty), 32'(m_count <= int'(AE)));
        chk({ph, ":overflow"},     32'(bus.overflow),     32'(m_ovf));
        chk({ph, ":underflow"},    32'(bus.underflow),    32'(m_udf));
        chk({ph, ":ptr_err"},      32'(bus.ptr_err),      32'(m_perr));
    endtask

    // One clock of stimulus: check grants mid-cycle, then advance model and check registered state
    task automatic step(input string ph, input bit wr, input bit rd, input bit clr);
        bit gw, gr, mism;
        int diff;
        @(negedge clk);
        bus.wr_req  = wr;
        bus.rd_req  = rd;
        bus.err_clr = clr;
        #1;
        gw   = wr && (m_count < int'(DEPTH));
        gr   = rd && (m_count > 0);
        diff = (int'(bus.w_ptr) - int'(bus.r_ptr) + PMOD) % PMOD;
        mism = (diff != m_count);
        chk({ph, ":cw_en"}, 32'(bus.cw_en), 32'(gw));
        chk({ph, ":cr_en"}, 32'(bus.cr_en), 32'(gr));
        @(posedge clk);
        #1;
        m_ovf   = (wr && m_count == int'(DEPTH)) || (m_ovf && !clr);
        m_udf   = (rd && m_count == 0) || (m_udf && !clr);
        m_perr  = mism || (m_perr && !clr);
        m_count = m_count + int'(gw) - int'(gr);
        check_all(ph);
    endtask

    // Reset asserted away from any clock edge to exercise the asynchronous path
    task automatic do_reset(input string ph);
        @(negedge clk);
        #2;
        rst         = 1'b1;
        ptr_off     = '0;
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.err_clr = 1'b0;
        #1;
        m_count = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_perr  = 1'b0;
        check_all(ph);
        chk({ph, ":cw_en"}, 32'(bus.cw_en), 32'(0));
        chk({ph, ":cr_en"}, 32'(bus.cr_en), 32'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.err_clr = 1'b0;
        do_reset("rst0");
        step("idle", 0, 0, 0);

        // Fill to full, then one more write overflows
        for (int i = 0; i < 4; i++) step("fill", 1, 0, 0);
        step("wr_full", 1, 0, 0);
        step("both_full", 1, 1, 0);
        step("clr_ovf", 0, 0, 1);

        // Drain, underflow at empty, clear, simultaneous at empty
        for (int i = 0; i < 3; i++) step("drain", 0, 1, 0);
        step("rd_empty", 0, 1, 0);
        step("clr_udf", 0, 0, 1);
        step("rd_clr_same", 0, 1, 1);
        step("clr_udf2", 0, 0, 1);
        step("both_empty", 1, 1, 0);

        // Half-full streaming with pointers wrapping the MSB
        step("to_half", 1, 0, 0);
        for (int i = 0; i < 10; i++) step("stream", 1, 1, 0);

        // Randomized traffic with occasional error clears
        for (int i = 0; i < 300; i++) begin
            bit wr, rd, clr;
            int bias;
            bias = (i / 25) % 3;
            wr   = ($urandom_range(0, 3) < ((bias == 0) ? 3 : (bias == 1) ? 1 : 2));
            rd   = ($urandom_range(0, 3) < ((bias == 0) ? 1 : (bias == 1) ? 3 : 2));
            clr  = ($urandom_range(0, 15) == 0);
            step("rand", wr, rd, clr);
        end

        // Pointer mismatch: sticky even while clear is requested during the fault
        step("clr_pre", 0, 0, 1);
        step("prep", 1, 0, 0);
        ptr_off = PW'(1);
        step("perr_set", 0, 0, 0);
        step("perr_hold", 1, 0, 0);
        step("perr_clr_fault", 0, 0, 1);
        ptr_off = '0;
        step("perr_clr", 0, 0, 1);
        step("perr_idle", 0, 0, 0);

        // Mid-stream asynchronous reset with state set
        step("pre_rst", 1, 0, 0);
        ptr_off = PW'(2);
        step("pre_rst_err", 1, 1, 0);
        do_reset("rst_mid");
        step("post_rst", 1, 0, 0);
        step("post_rst2", 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
